// File: rtl/fphub_special_classifier.sv
// Operand classification stage ahead of the FPHUB adder special-result logic.
// Codes are computed on the input side and registered with the data through a 2-entry skid buffer.
module fphub_special_classifier #(
  parameter int M            = 23,
  parameter int E            = 8,
  parameter int special_case = 7,
  parameter int CW           = $clog2(special_case)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [E+M:0]     X,
  input  logic [E+M:0]     Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [E+M:0]     X_out,
  output logic [E+M:0]     Y_out,
  output logic [CW-1:0]    X_special_case,
  output logic [CW-1:0]    Y_special_case,
  output logic             is_special
);

  localparam int W = E + M + 1;

  localparam logic [CW-1:0] C_NONE  = CW'(0);
  localparam logic [CW-1:0] C_PINF  = CW'(1);
  localparam logic [CW-1:0] C_NINF  = CW'(2);
  localparam logic [CW-1:0] C_PZERO = CW'(3);
  localparam logic [CW-1:0] C_NZERO = CW'(4);
  localparam logic [CW-1:0] C_PONE  = CW'(5);
  localparam logic [CW-1:0] C_NONE1 = CW'(6);

  // Exponent all ones is only INF with an all-ones mantissa; anything else there is a normal value.
  function automatic logic [CW-1:0] classify(input logic [W-1:0] v);
    logic         s;
    logic [E-1:0] e;
    logic [M-1:0] m;
    logic [CW-1:0] c;
    s = v[W-1];
    e = v[W-2:M];
    m = v[M-1:0];
    if ((&e) && (&m))
      c = s ? C_NINF : C_PINF;
    else if (!(|e) && !(|m))
      c = s ? C_NZERO : C_PZERO;
    else if ((e == {1'b1, {(E-1){1'b0}}}) && !(|m))
      c = s ? C_NONE1 : C_PONE;
    else
      c = C_NONE;
    return c;
  endfunction

  logic [CW-1:0] x_code_in, y_code_in;
  assign x_code_in = classify(X);
  assign y_code_in = classify(Y);

  logic          main_valid, skid_valid;
  logic [W-1:0]  main_x, main_y, skid_x, skid_y;
  logic [CW-1:0] main_xc, main_yc, skid_xc, skid_yc;
  logic          accept, pop;

  assign in_ready = !skid_valid & !rst;
  assign accept   = in_valid & in_ready;
  assign pop      = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_x     <= '0;
      main_y     <= '0;
      main_xc    <= '0;
      main_yc    <= '0;
      skid_x     <= '0;
      skid_y     <= '0;
      skid_xc    <= '0;
      skid_yc    <= '0;
    end else begin
      if (!main_valid || pop) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_x     <= skid_x;
          main_y     <= skid_y;
          main_xc    <= skid_xc;
          main_yc    <= skid_yc;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_x     <= X;
          main_y     <= Y;
          main_xc    <= x_code_in;
          main_yc    <= y_code_in;
        end else begin
          main_valid <= 1'b0;
        end
      end
      // Skid only fills when main is occupied and not draining this cycle.
      if (accept && main_valid && !pop) begin
        skid_valid <= 1'b1;
        skid_x     <= X;
        skid_y     <= Y;
        skid_xc    <= x_code_in;
        skid_yc    <= y_code_in;
      end else if (skid_valid && pop) begin
        skid_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = main_valid;
  assign X_out          = main_x;
  assign Y_out          = main_y;
  assign X_special_case = main_xc;
  assign Y_special_case = main_yc;
  assign is_special     = (|main_xc) | (|main_yc);

endmodule

// File: tb/tb_fphub_special_classifier.sv
// Bench for fphub_special_classifier: scoreboard queue filled on accept, drained by an output monitor.
module tb_fphub_special_classifier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] X, Y;
  logic        out_valid, out_ready;
  logic [31:0] X_out, Y_out;
  logic [2:0]  X_special_case, Y_special_case;
  logic        is_special;

  int n_checks = 0;
  int n_fail   = 0;

  fphub_special_classifier #(.M(23), .E(8), .special_case(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
    .out_valid(out_valid), .out_ready(out_ready),
    .X_out(X_out), .Y_out(Y_out),
    .X_special_case(X_special_case), .Y_special_case(Y_special_case),
    .is_special(is_special)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_class(input logic [31:0] v);
    int unsigned ex, mn;
    ex = (v >> 23) & 255;
    mn = v & 32'h007F_FFFF;
    if (ex == 255 && mn == 8388607) return v[31] ? 3'd2 : 3'd1;
    if (ex == 0 && mn == 0)         return v[31] ? 3'd4 : 3'd3;
    if (ex == 128 && mn == 0)       return v[31] ? 3'd6 : 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [70:0] ref_out(input logic [31:0] x, input logic [31:0] y);
    logic [2:0] cx, cy;
    cx = ref_class(x);
    cy = ref_class(y);
    return {x, y, cx, cy, (cx != 0) || (cy != 0)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [70:0] q[$];
  logic        hold_valid = 1'b0;
  logic [70:0] hold_val;
  logic [70:0] cur;

  always @(negedge clk) begin
    cur = {X_out, Y_out, X_special_case, Y_special_case, is_special};
    if (rst) begin
      q.delete();
      hold_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h, expected no output", cur);
        end else begin
          chk("out_pair", 128'(cur), 128'(q[0]));
          if (out_ready) void'(q.pop_front());
        end
        if (hold_valid) chk("stall_stable", 128'(cur), 128'(hold_val));
      end
      hold_valid = out_valid && !out_ready;
      hold_val   = cur;
      if (in_valid && in_ready) q.push_back(ref_out(X, Y));
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    bit acc;
    int n;
    in_valid = 1'b1;
    X = x;
    Y = y;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: pair %0h/%0h never accepted", x, y);
    end
  endtask

  logic [31:0] sweep_x[8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                              32'h40000000, 32'hC0000000, 32'h7F800000, 32'h40000001};
  logic [2:0]  sweep_c[8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0, 3'd0};
  logic [31:0] specials[8] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000,
                               32'h40000000, 32'hC0000000, 32'h7F800000, 32'h3F800000};

  function automatic logic [31:0] rand_op();
    if ($urandom_range(1, 0) == 1) return specials[$urandom_range(7, 0)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0;
    @(negedge clk);
    chk("in_ready_in_rst", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_outputs", 128'({X_out, Y_out, X_special_case, Y_special_case, is_special}), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // Classification sweep, one pair at a time
    for (int i = 0; i < 8; i++) begin
      send(sweep_x[i], 32'h3F000000);
      in_valid = 1'b0;
      @(negedge clk);
      chk("sweep_valid", 128'(out_valid), 128'(1));
      chk("sweep_xcode", 128'(X_special_case), 128'(sweep_c[i]));
      chk("sweep_ycode", 128'(Y_special_case), 128'(0));
      chk("sweep_is_special", 128'(is_special), 128'(i < 6));
      @(posedge clk); #1;
    end

    // Streaming
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      X = 32'h1000_0000 + i;
      Y = 32'h2000_0000 + i;
      @(negedge clk);
      chk("stream_in_ready", 128'(in_ready), 128'(1));
      if (i > 0) chk("stream_out_valid", 128'(out_valid), 128'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", 128'(out_valid), 128'(1));
    chk("stream_last_x", 128'(X_out), 128'(32'h1000_0007));
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Back-pressure: two pairs absorbed, third blocked
    out_ready = 1'b0;
    send(32'hA000_0001, 32'hB000_0001);
    send(32'hA000_0002, 32'hB000_0002);
    in_valid = 1'b1; X = 32'hA000_0003; Y = 32'hB000_0003;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      chk("bp_hold_x", 128'(X_out), 128'(32'hA000_0001));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'hA000_0003, 32'hB000_0003);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk("bp_drained", 128'(q.size()), 128'(0));

    // Random traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      X = rand_op();
      Y = rand_op();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk("random_drained", 128'(q.size()), 128'(0));

    // Reset with skid full
    out_ready = 1'b0;
    send(32'h1111_1111, 32'h2222_2222);
    send(32'h3333_3333, 32'h4444_4444);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 128'(out_valid), 128'(0));
    chk("post_rst_outputs", 128'({X_out, Y_out, X_special_case, Y_special_case, is_special}), 128'(0));
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // Mixed pair after reset
    out_ready = 1'b1;
    send(32'hFFFFFFFF, 32'h80000000);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mixed_valid", 128'(out_valid), 128'(1));
    chk("mixed_xcode", 128'(X_special_case), 128'(2));
    chk("mixed_ycode", 128'(Y_special_case), 128'(4));
    chk("mixed_is_special", 128'(is_special), 128'(1));
    chk("mixed_data", 128'({X_out, Y_out}), 128'({32'hFFFFFFFF, 32'h80000000}));
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    chk("final_drained", 128'(q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fphub_special_classifier.md
Name: fphub_special_classifier

Overview:
- Registered operand classification stage directly upstream of the FPHUB adder's special-result logic.
- Accepts an operand pair (X, Y) on a valid/ready handshake and classifies each operand into a 3-bit special-case code.
- Forwards the operands, both codes and a combined `is_special` flag one cycle later through a 2-entry skid buffer.
- `in_ready` is driven from a register only, so there is no combinational ready path from output to input.

Parameters:
- M, 23, mantissa width
- E, 8, exponent width
- special_case, 7, number of special-case codes including "none"; code width CW = $clog2(special_case) = 3

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  X/Y pair presented
- in_ready  output  1  stage can accept a pair this cycle
- X  input  E+M+1  operand X (sign, exponent, mantissa)
- Y  input  E+M+1  operand Y
- out_valid  output  1  classified pair available
- out_ready  input  1  downstream adder consumes the pair
- X_out  output  E+M+1  registered X
- Y_out  output  E+M+1  registered Y
- X_special_case  output  CW  class code of X_out
- Y_special_case  output  CW  class code of Y_out
- is_special  output  1  high when either code is nonzero

Behaviour:
- Class codes: 0 NONE, 1 +INF, 2 -INF, 3 +ZERO, 4 -ZERO, 5 +ONE, 6 -ONE. Code 7 is never produced.
- Classification per operand (s = MSB, e = next E bits, m = low M bits), in priority order:
  - e all ones and m all ones → INF (1 if s=0, else 2).
  - e all zeros and m all zeros → ZERO (3/4 by sign).
  - e = {1'b1, (E-1){1'b0}} and m all zeros → ONE (5/6 by sign).
  - Otherwise → NONE.
- Exponent all ones with m not all ones is NONE: it is an ordinary number, not NaN.
- Classification is computed combinationally on the input and registered with the data. No classification logic sits on the output side.
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds {X, Y, Xcode, Ycode} plus a valid bit.
- Handshake events: accept = in_valid & in_ready; pop = out_valid & out_ready.
- `in_ready` = !skid_valid & !rst. It depends on registered state only.
- Main entry update, per cycle:
  - Main empty, or pop: main ← skid if skid_valid, else accepted input if accept, else main becomes invalid.
  - Main valid and no pop: main holds.
- Skid entry update, per cycle:
  - Accept while main is valid and not popping: skid ← input, skid_valid ← 1.
  - Skid moved to main on pop: skid_valid ← 0.
- Latency: an accepted pair appears on the outputs the next cycle when the stage is empty.
- Throughput: 1 pair/cycle while out_ready=1.
- Back-pressure: with out_ready=0, the stage absorbs exactly 2 pairs and then `in_ready` drops the cycle after the second accept.
- Output stability: while out_valid=1 and out_ready=0, every output holds its value. Order is strictly FIFO.
- Simultaneous pop with skid_valid=1: skid moves to main and in_ready rises the next cycle. No input is accepted that cycle.
- Simultaneous accept and pop with skid empty: the new pair goes directly to main, with no bubble.
- Reset, including mid-transfer:
  - Next edge: both valid bits cleared, out_valid=0, all data/code outputs 0, is_special=0.
  - in_ready=0 while rst is high and 1 on the first cycle after.
  - In-flight pairs are discarded.
- out_valid is never asserted while its codes are stale: codes always belong to X_out/Y_out.

Test Plan:
- Classification sweep (M=23, E=8), out_ready=1. X inputs, each with Y=0x3F000000:
  - 0x7FFFFFFF → X_special_case=1
  - 0xFFFFFFFF → 2
  - 0x00000000 → 3
  - 0x80000000 → 4
  - 0x40000000 → 5
  - 0xC0000000 → 6
  - 0x7F800000 → 0
  - 0x40000001 → 0
  - Y_special_case=0 throughout. is_special is 1 exactly for the first six.
- Streaming: 8 back-to-back pairs with out_ready=1 → out_valid continuous from cycle 1, 1 pair/cycle, in order, in_ready stays 1.
- Back-pressure: out_ready=0, in_valid=1 with 3 distinct pairs → pairs 1 and 2 accepted, in_ready=0 from the cycle after the 2nd accept, outputs hold pair 1. Release out_ready → pairs 1, 2, 3 emerged in order with no loss or duplication.
- Random out_ready/in_valid (≥10k cycles) vs. reference FIFO model → identical sequence, and outputs are stable whenever out_valid & !out_ready.
- Reset mid-operation: skid full, assert rst for 1 cycle → next cycle out_valid=0, outputs 0, in_ready=0 during rst and 1 after. A new pair then emerges with correct codes.
- Mixed pair X=0xFFFFFFFF, Y=0x80000000 → X_special_case=2, Y_special_case=4, is_special=1, X_out/Y_out equal to the inputs.
